mem_bus_controller: RTL and testbench

Sits directly downstream of the processor core's memory request path and drives the external asynchronous SRAM/peripheral bus (ADDR_BUF, DOUT_BUF, DIN, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, DBUS_OEN). It turns a single-cycle-accepted read/write request into a setup/strobe/hold bus cycle with programmable wait states, byte-lane write strobes and an external WAITN extension. It also hands the bus to an external master (DMA/debugger) via BUSRQN/BUSAKN.

---
 rtl/mem_bus_controller.sv | 151 +++++++++++++++
 tb/tb_mem_bus_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: turns single-cycle core read/write requests into
// setup/strobe/hold cycles on an external asynchronous SRAM/peripheral bus,
// with programmable wait states, byte-lane write strobes, WAITN stretching
// and hand-over of the bus to an external master through BUSRQN/BUSAKN.
module mem_bus_controller #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ_RD,
    input  logic        REQ_WR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    output logic        ACK,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic [15:0] ADDR_BUF,
    output logic [15:0] DOUT_BUF,
    input  logic [15:0] DIN,
    output logic        RDN_BUF,
    output logic        WRN0_BUF,
    output logic        WRN1_BUF,
    output logic        ABUS_OEN,
    output logic        DBUS_OEN,
    input  logic        WAITN,
    input  logic        BUSRQN,
    output logic        BUSAKN
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        HIZ
    } state_t;

    localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        is_read;
    logic [1:0]  be_lat;
    logic        busrq_meta;
    logic        busrq_sync;
    logic        granted;
    logic        bus_en;
    logic        accept;
    logic        in_cycle;

    assign accept   = (state == IDLE) && (state_next == SETUP);
    assign in_cycle = (state == SETUP) || (state == STROBE) || (state == HOLD);

    // Two-flop synchroniser for the asynchronous external bus request
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            busrq_meta <= 1'b1;
            busrq_sync <= 1'b1;
        end else begin
            busrq_meta <= BUSRQN;
            busrq_sync <= busrq_meta;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: bus hand-over beats reads, reads beat writes
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!busrq_sync) begin
                    state_next = HIZ;
                end else if (REQ_RD || REQ_WR) begin
                    state_next = SETUP;
                end
            end
            SETUP:  state_next = STROBE;
            STROBE: begin
                if ((wait_cnt == 4'd0) && WAITN) begin
                    state_next = HOLD;
                end
            end
            HOLD:   state_next = IDLE;
            HIZ: begin
                if (busrq_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction capture at acceptance, wait countdown and read-data capture
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ADDR_BUF <= 16'h0000;
            DOUT_BUF <= 16'h0000;
            RDATA    <= 16'h0000;
            wait_cnt <= 4'd0;
            is_read  <= 1'b0;
            be_lat   <= 2'b00;
        end else begin
            if (accept) begin
                ADDR_BUF <= REQ_ADDR;
                is_read  <= REQ_RD;
                be_lat   <= REQ_BE;
                wait_cnt <= WAIT_LOAD;
                if (!REQ_RD) begin
                    DOUT_BUF <= REQ_DATA;
                end
            end
            if ((state == STROBE) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if ((state == STROBE) && (state_next == HOLD) && is_read) begin
                RDATA <= DIN;
            end
        end
    end

    // Grant flag (from the second HIZ cycle) and post-reset address enable
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            granted <= 1'b0;
            bus_en  <= 1'b0;
        end else begin
            granted <= (state == HIZ) && !busrq_sync;
            bus_en  <= 1'b1;
        end
    end

    assign BUSY     = (state != IDLE);
    assign ACK      = (state == HOLD);
    assign RDN_BUF  = !((state == STROBE) && is_read);
    assign WRN0_BUF = !((state == STROBE) && !is_read && be_lat[0]);
    assign WRN1_BUF = !((state == STROBE) && !is_read && be_lat[1]);
    assign ABUS_OEN = !(bus_en && (state != HIZ));
    assign DBUS_OEN = !(in_cycle && !is_read);
    assign BUSAKN   = !(granted && (state == HIZ) && !busrq_sync);

endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: drives directed and random bus transactions,
// emulates an external SRAM on the bus pins and compares every observed
// transaction against a transaction-level memory and timing model.
module tb_mem_bus_controller;

    localparam int W = 2;

    logic        CLK;
    logic        RESETN;
    logic        REQ_RD;
    logic        REQ_WR;
    logic [1:0]  REQ_BE;
    logic [15:0] REQ_ADDR;
    logic [15:0] REQ_DATA;
    logic        ACK;
    logic [15:0] RDATA;
    logic        BUSY;
    logic [15:0] ADDR_BUF;
    logic [15:0] DOUT_BUF;
    logic [15:0] DIN;
    logic        RDN_BUF;
    logic        WRN0_BUF;
    logic        WRN1_BUF;
    logic        ABUS_OEN;
    logic        DBUS_OEN;
    logic        WAITN;
    logic        BUSRQN;
    logic        BUSAKN;

    int          checkCount;
    int          passCount;
    logic [15:0] lastRead;
    logic [15:0] sramMem [logic [15:0]];
    logic [15:0] refMem  [logic [15:0]];
    logic [15:0] addrPool [6];

    mem_bus_controller #(.WAIT_STATES(W)) dut (
        .CLK(CLK), .RESETN(RESETN), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
        .REQ_BE(REQ_BE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .ADDR_BUF(ADDR_BUF),
        .DOUT_BUF(DOUT_BUF), .DIN(DIN), .RDN_BUF(RDN_BUF),
        .WRN0_BUF(WRN0_BUF), .WRN1_BUF(WRN1_BUF), .ABUS_OEN(ABUS_OEN),
        .DBUS_OEN(DBUS_OEN), .WAITN(WAITN), .BUSRQN(BUSRQN), .BUSAKN(BUSAKN)
    );

    // Free-running 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [15:0] sramRead(input logic [15:0] a);
        return sramMem.exists(a) ? sramMem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : 16'h0000;
    endfunction

    // One complete core transaction; ext = extra cycles WAITN is held low
    // once the wait-state count has expired. keepWr leaves REQ_WR pending
    // behind a read.
    task automatic applyStimulus(input bit rd, input bit keepWr, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [1:0] be, input int ext);
        int ackAt, rdnLow, wrn0Low, wrn1Low, dbusLow, addrBad, doutBad, abusBad;
        int strobeLen, lastStrobe;
        logic [15:0] v, expRead;
        ackAt = 0; rdnLow = 0; wrn0Low = 0; wrn1Low = 0; dbusLow = 0;
        addrBad = 0; doutBad = 0; abusBad = 0;
        strobeLen  = 1 + W + ext;
        lastStrobe = 1 + strobeLen;
        @(negedge CLK);
        checkOutput("idle_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("ack_single", {31'd0, ACK}, 32'd0);
        REQ_RD = rd; REQ_WR = !rd || keepWr;
        REQ_ADDR = addr; REQ_DATA = data; REQ_BE = be;
        WAITN = 1'b1; DIN = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (!RDN_BUF) rdnLow++;
            if (!WRN0_BUF) begin
                wrn0Low++;
                v = sramRead(ADDR_BUF); v[7:0] = DOUT_BUF[7:0]; sramMem[ADDR_BUF] = v;
            end
            if (!WRN1_BUF) begin
                wrn1Low++;
                v = sramRead(ADDR_BUF); v[15:8] = DOUT_BUF[15:8]; sramMem[ADDR_BUF] = v;
            end
            if (!DBUS_OEN) dbusLow++;
            if (ADDR_BUF !== addr) addrBad++;
            if (!rd && !DBUS_OEN && (DOUT_BUF !== data)) doutBad++;
            if (ABUS_OEN !== 1'b0) abusBad++;
            if (ACK) begin
                ackAt = c;
                REQ_RD = 1'b0;
                REQ_WR = rd && keepWr;
                break;
            end
            WAITN = !((c >= 2 + W) && (c < 2 + W + ext));
            DIN = (rd && (c == lastStrobe)) ? sramRead(ADDR_BUF) : 16'($urandom);
        end
        WAITN = 1'b1;
        if (ackAt == 0) begin
            REQ_RD = 1'b0; REQ_WR = 1'b0;
        end
        checkOutput("ack_latency", ackAt, 3 + W + ext);
        checkOutput("rdn_cycles", rdnLow, rd ? strobeLen : 0);
        checkOutput("wrn0_cycles", wrn0Low, (!rd && be[0]) ? strobeLen : 0);
        checkOutput("wrn1_cycles", wrn1Low, (!rd && be[1]) ? strobeLen : 0);
        checkOutput("dbus_cycles", dbusLow, rd ? 0 : strobeLen + 2);
        checkOutput("addr_stable", addrBad, 0);
        checkOutput("dout_stable", doutBad, 0);
        checkOutput("abus_enabled", abusBad, 0);
        if (rd) begin
            expRead = refRead(addr);
            checkOutput("rdata", {16'd0, RDATA}, {16'd0, expRead});
            lastRead = expRead;
        end else begin
            v = refRead(addr);
            if (be[0]) v[7:0]  = data[7:0];
            if (be[1]) v[15:8] = data[15:8];
            refMem[addr] = v;
            checkOutput("rdata_kept", {16'd0, RDATA}, {16'd0, lastRead});
        end
    endtask

    // External master takes the bus while a core read waits, then returns it
    task automatic busHandover(input logic [15:0] addr);
        int lowAt, highAt, hizBad;
        lowAt = 0; highAt = 0; hizBad = 0;
        @(negedge CLK);
        BUSRQN = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                REQ_RD = 1'b1; REQ_ADDR = addr;
            end
            if (!RDN_BUF || !WRN0_BUF || !WRN1_BUF) hizBad++;
            if (!BUSAKN) begin
                lowAt = i;
                break;
            end
        end
        checkOutput("busak_fall_edges", lowAt, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if ({ABUS_OEN, DBUS_OEN, BUSAKN, BUSY, RDN_BUF, WRN0_BUF, WRN1_BUF, ACK}
                !== 8'b11011110) hizBad++;
        end
        checkOutput("hiz_outputs", hizBad, 0);
        BUSRQN = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (BUSAKN) begin
                highAt = i;
                break;
            end
        end
        checkOutput("busak_rise_edges", highAt, 2);
        applyStimulus(1'b1, 1'b0, addr, 16'h0000, 2'b00, 0);
    endtask

    initial begin
        logic [15:0] a;
        logic        rd;
        int          ext;
        checkCount = 0; passCount = 0; lastRead = 16'h0000;
        RESETN = 1'b0; REQ_RD = 1'b0; REQ_WR = 1'b0; REQ_BE = 2'b00;
        REQ_ADDR = 16'h0000; REQ_DATA = 16'h0000; DIN = 16'h0000;
        WAITN = 1'b1; BUSRQN = 1'b1;
        for (int i = 0; i < 6; i++) addrPool[i] = 16'($urandom);

        repeat (3) @(negedge CLK);
        checkOutput("reset_ctrl",
            {24'd0, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, DBUS_OEN, BUSAKN, ACK, BUSY},
            32'h000000FC);
        checkOutput("reset_addr", {16'd0, ADDR_BUF}, 32'd0);
        checkOutput("reset_dout", {16'd0, DOUT_BUF}, 32'd0);
        checkOutput("reset_rdata", {16'd0, RDATA}, 32'd0);
        RESETN = 1'b1;
        @(negedge CLK);
        checkOutput("idle_abus", {31'd0, ABUS_OEN}, 32'd0);

        // Directed transactions
        applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0055, 2'b11, 0);
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0);
        applyStimulus(1'b0, 1'b0, 16'h00AF, 16'hA1B2, 2'b01, 0);
        applyStimulus(1'b0, 1'b0, 16'h00AF, 16'hC3D4, 2'b10, 0);
        applyStimulus(1'b1, 1'b0, 16'h00AF, 16'h0000, 2'b00, 4);
        applyStimulus(1'b0, 1'b0, 16'h00AF, 16'hFFFF, 2'b00, 0);
        applyStimulus(1'b1, 1'b0, 16'h00AF, 16'h0000, 2'b00, 0);
        applyStimulus(1'b1, 1'b1, 16'h4321, 16'hBEEF, 2'b11, 0);
        applyStimulus(1'b0, 1'b0, 16'h4321, 16'hBEEF, 2'b11, 0);
        applyStimulus(1'b1, 1'b0, 16'h4321, 16'h0000, 2'b00, 1);
        busHandover(16'h1234);

        // Random traffic over a small address pool
        for (int n = 0; n < 30; n++) begin
            a   = addrPool[$urandom_range(0, 5)];
            rd  = 1'($urandom_range(0, 1));
            ext = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            applyStimulus(rd, 1'b0, a, 16'($urandom), 2'($urandom), ext);
        end

        // Reset asserted in the middle of a write strobe
        @(negedge CLK);
        REQ_WR = 1'b1; REQ_ADDR = 16'h5A5A; REQ_DATA = 16'h1111; REQ_BE = 2'b11;
        repeat (2) @(negedge CLK);
        checkOutput("pre_reset_strobe", {30'd0, WRN0_BUF, WRN1_BUF}, 32'd0);
        #2 RESETN = 1'b0;
        #1;
        checkOutput("async_reset_ctrl",
            {26'd0, WRN0_BUF, WRN1_BUF, ABUS_OEN, DBUS_OEN, BUSY, ACK}, 32'h0000003C);
        REQ_WR = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_no_ack", {31'd0, ACK}, 32'd0);
        RESETN = 1'b1;
        @(negedge CLK);
        checkOutput("post_reset_idle", {30'd0, ABUS_OEN, BUSY}, 32'd0);
        checkOutput("post_reset_rdata", {16'd0, RDATA}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
